// File: rtl/median_filter_pkg.sv
// Shared definitions for the median filter: controller states and the
// fixed schedule constants of the sort network.
package median_filter_pkg;

  // Controller phases, in the order a window travels through them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPARE = 3'd2,
    BYPASS  = 3'd3,
    FINAL   = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Pixels per 3x3 window.
  localparam int NB_PIXEL = 9;
  // Number of maximum-extraction passes before the final compare.
  localparam int NB_PASS = 4;
  // Compare cycles in the final phase (the 5 remaining candidates).
  localparam int FINAL_CMP = 4;

endpackage

// File: rtl/median_filter_med.sv
// MED datapath: a chain of NB_PIXEL pixel registers with one compare/swap
// element between the last two stages. The last register is the "carry"
// that collects the maximum while the other stages rotate past it.
//
// Mode select {BYP, DSI}:
//   11 : shift DI into stage 0, the whole chain moves by one
//   10 : rotate the full ring (last stage feeds stage 0)
//   00 : compare: last stage keeps max(last, last-1), the min re-enters
//        stage 0, stages 1..N-2 shift by one
//   01 : hold
// Pixel registers are intentionally not reset.
module median_filter_med #(
  parameter int SIZE     = 8,
  parameter int NB_PIXEL = 9
) (
  input  logic            CLK,
  input  logic [SIZE-1:0] DI,
  input  logic            DSI,
  input  logic            BYP,
  output logic [SIZE-1:0] DO
);

  logic [SIZE-1:0] r [NB_PIXEL];
  logic [SIZE-1:0] hi;
  logic [SIZE-1:0] lo;

  // Compare/swap element on the two last stages.
  always_comb begin
    hi = r[NB_PIXEL-1];
    lo = r[NB_PIXEL-2];
    if (r[NB_PIXEL-2] > r[NB_PIXEL-1]) begin
      hi = r[NB_PIXEL-2];
      lo = r[NB_PIXEL-1];
    end
  end

  // Pixel chain update according to the selected mode.
  always_ff @(posedge CLK) begin
    case ({BYP, DSI})
      2'b11: begin
        r[0] <= DI;
        for (int i = 1; i < NB_PIXEL; i++) r[i] <= r[i-1];
      end
      2'b10: begin
        r[0] <= r[NB_PIXEL-1];
        for (int i = 1; i < NB_PIXEL; i++) r[i] <= r[i-1];
      end
      2'b00: begin
        r[0]          <= lo;
        r[NB_PIXEL-1] <= hi;
        for (int i = 1; i < NB_PIXEL - 1; i++) r[i] <= r[i-1];
      end
      default: begin
        for (int i = 0; i < NB_PIXEL; i++) r[i] <= r[i];
      end
    endcase
  end

  assign DO = r[NB_PIXEL-1];

endmodule

// File: rtl/median_filter.sv
// 3x3 median filter: controller FSM sequencing one MED datapath.
//
// Strobe protocol (no back-pressure): DSI is held high for exactly
// NB_PIXEL consecutive cycles to deliver one window, one pixel per cycle.
// A window may only start while the controller is IDLE; DSI is ignored
// while a window is being sorted. DSO is a single-cycle registered pulse
// and DO is valid only during that cycle.
//
// Schedule after the 9th pixel: pass p (0..3) compares 8-p cycles to pull
// the current maximum into the carry stage, then rotates p+1 cycles so the
// extracted maxima pile up at the head of the chain, out of reach of the
// next pass. After four maxima are removed, FINAL takes the maximum of the
// five survivors, which is the median. Total 40 cycles.
module median_filter #(
  parameter int SIZE     = 8,
  parameter int NB_PIXEL = 9
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [SIZE-1:0]           DI,
  input  logic                      DSI,
  output logic [SIZE-1:0]           DO,
  output logic                      DSO,
  output median_filter_pkg::state_t dbg_state
);

  import median_filter_pkg::*;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [2:0] pass;
  logic [2:0] pass_n;
  logic [3:0] cmp_last;
  logic       dso_n;
  logic       med_dsi;
  logic       med_byp;

  // Last compare cycle index of the current pass: 8-p cycles -> 7-p.
  assign cmp_last = 4'(NB_PIXEL - 2) - {1'b0, pass};

  // State, counters and output strobe registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      pass  <= '0;
      DSO   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pass  <= pass_n;
      DSO   <= dso_n;
    end
  end

  // Next-state, counter updates and MED mode controls.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pass_n  = pass;
    med_dsi = 1'b0;
    med_byp = 1'b0;
    case (state)
      IDLE: begin
        med_byp = 1'b1;
        med_dsi = DSI;
        if (DSI) begin
          state_n = LOAD;
          cnt_n   = 4'd1;
        end
      end
      LOAD: begin
        med_byp = 1'b1;
        med_dsi = 1'b1;
        if (DSI) begin
          if (cnt == 4'(NB_PIXEL - 1)) begin
            state_n = COMPARE;
            cnt_n   = '0;
            pass_n  = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end else begin
          // Short window: drop it.
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      COMPARE: begin
        if (cnt == cmp_last) begin
          state_n = BYPASS;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      BYPASS: begin
        med_byp = 1'b1;
        if (cnt == {1'b0, pass}) begin
          cnt_n = '0;
          if (pass == 3'(NB_PASS - 1)) begin
            state_n = FINAL;
            pass_n  = '0;
          end else begin
            state_n = COMPARE;
            pass_n  = pass + 3'd1;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      FINAL: begin
        if (cnt == 4'(FINAL_CMP - 1)) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        pass_n  = '0;
      end
    endcase
    dso_n = (state_n == DONE);
  end

  median_filter_med #(
    .SIZE     (SIZE),
    .NB_PIXEL (NB_PIXEL)
  ) u_med (
    .CLK (CLK),
    .DI  (DI),
    .DSI (med_dsi),
    .BYP (med_byp),
    .DO  (DO)
  );

  assign dbg_state = state;

endmodule
